fifo_drain_packer: RTL and testbench

FIFO_DRAIN_PACKER -- requirements
Module: fifo_drain_packer

---
 rtl/fifo_drain_packer.sv | 172 +++++++++++++++++
 tb/tb_fifo_drain_packer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain_packer.sv
// Drains a one-cycle-latency FIFO read port and packs PACK bytes into one output word with a byte-keep mask.
// Optional idle-timeout partial flush is enabled by defining FIFO_DRAIN_PACKER_TIMEOUT_EN.
module fifo_drain_packer #(
   parameter int unsigned DATA_WIDTH     = 8,
   parameter int unsigned PACK           = 4,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                         rclk,
   input  logic                         rrst,
   input  logic                         fifo_empty,
   input  logic [DATA_WIDTH-1:0]        fifo_rdata,
   output logic                         fifo_r_en,
   input  logic                         flush,
   output logic [DATA_WIDTH*PACK-1:0]   m_data,
   output logic [PACK-1:0]              m_keep,
   output logic                         m_valid,
   input  logic                         m_ready,
   output logic                         busy
);

   localparam int unsigned CW = 4;
   localparam int unsigned WW = DATA_WIDTH * PACK;

   if (PACK < 2 || PACK > 8) begin : g_bad_pack
      $error("PACK must be in 2..8");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   logic            r_run;
   logic [CW-1:0]   r_count;
   logic            r_inflight;
   logic [WW-1:0]   r_acc;
   logic            r_flush_pend;
   logic            r_flush_next;
   logic [WW-1:0]   r_m_data;
   logic [PACK-1:0] r_m_keep;
   logic            r_m_valid;
   logic            r_busy;

   logic            w_rd;
   logic            w_full;
   logic            w_slot_free;
   logic            w_flush_req;
   logic            w_xfer_full;
   logic            w_xfer_part;
   logic            w_xfer;
   logic [CW-1:0]   w_count_n;
   logic [WW-1:0]   w_acc_n;
   logic [PACK-1:0] w_keep;
   logic            w_pend_n;
   logic            w_next_n;
   logic            w_valid_n;
   logic            w_busy_n;

`ifdef FIFO_DRAIN_PACKER_TIMEOUT_EN
   localparam int unsigned IW = $clog2(TIMEOUT_CYCLES + 1);

   logic [IW-1:0] r_idle;
   logic          w_timeout;

   // Idle counter restarts on every landed byte and whenever the accumulator is empty.
   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         r_idle <= '0;
      end else if (r_inflight || w_xfer || (r_count == '0)) begin
         r_idle <= '0;
      end else if (r_idle != IW'(TIMEOUT_CYCLES)) begin
         r_idle <= r_idle + IW'(1);
      end
   end

   assign w_timeout   = (r_idle == IW'(TIMEOUT_CYCLES));
   assign w_flush_req = r_flush_pend | w_timeout;
`else
   assign w_flush_req = r_flush_pend;
`endif

   // Reads are held off until the first edge after reset so none is issued during reset.
   assign w_rd        = r_run & ~fifo_empty & ((r_count + CW'(r_inflight)) < CW'(PACK));
   assign w_full      = (r_count == CW'(PACK));
   assign w_slot_free = ~r_m_valid | m_ready;
   assign w_xfer_full = w_full & w_slot_free;
   assign w_xfer_part = ~w_full & w_flush_req & (r_count != '0) & ~r_inflight & w_slot_free;
   assign w_xfer      = w_xfer_full | w_xfer_part;

   always_comb begin
      w_acc_n   = r_acc;
      w_count_n = r_count;
      w_keep    = '0;
      w_pend_n  = r_flush_pend;
      w_next_n  = r_flush_next;
      w_valid_n = r_m_valid;

      for (int i = 0; i < PACK; i++) begin
         w_keep[i] = (CW'(i) < r_count);
      end

      if (w_xfer) begin
         w_acc_n   = '0;
         w_count_n = '0;
      end
      // Landing byte goes to the next free lane, lane 0 if the word just left.
      if (r_inflight) begin
         for (int i = 0; i < PACK; i++) begin
            if (w_count_n == CW'(i)) begin
               w_acc_n[i*DATA_WIDTH +: DATA_WIDTH] = fifo_rdata;
            end
         end
         w_count_n = w_count_n + CW'(1);
      end

      // A flush seen while a full word waits is carried over to the following word.
      if (w_xfer_full) begin
         w_pend_n = r_flush_next | flush;
         w_next_n = 1'b0;
      end else if (w_xfer_part) begin
         w_pend_n = 1'b0;
         w_next_n = 1'b0;
      end else if (flush) begin
         if (w_full) begin
            w_next_n = 1'b1;
         end else if ((r_count != '0) || r_inflight) begin
            w_pend_n = 1'b1;
         end
      end

      if (w_xfer) begin
         w_valid_n = 1'b1;
      end else if (m_ready) begin
         w_valid_n = 1'b0;
      end

      w_busy_n = (w_count_n != '0) | w_rd | w_valid_n;
   end

   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         r_run        <= 1'b0;
         r_count      <= '0;
         r_inflight   <= 1'b0;
         r_acc        <= '0;
         r_flush_pend <= 1'b0;
         r_flush_next <= 1'b0;
         r_m_data     <= '0;
         r_m_keep     <= '0;
         r_m_valid    <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_run        <= 1'b1;
         r_count      <= w_count_n;
         r_inflight   <= w_rd;
         r_acc        <= w_acc_n;
         r_flush_pend <= w_pend_n;
         r_flush_next <= w_next_n;
         r_m_valid    <= w_valid_n;
         r_busy       <= w_busy_n;
         if (w_xfer) begin
            r_m_data <= r_acc;
            r_m_keep <= w_keep;
         end
      end
   end

   assign fifo_r_en = w_rd;
   assign m_data    = r_m_data;
   assign m_keep    = r_m_keep;
   assign m_valid   = r_m_valid;
   assign busy      = r_busy;

endmodule

// File: tb/tb_fifo_drain_packer.sv
// Directed bench for fifo_drain_packer with a small registered-read FIFO model and output word capture.
module tb_fifo_drain_packer;

   logic        rclk = 1'b0;
   logic        rrst;
   logic        fifo_empty;
   logic [7:0]  fifo_rdata;
   logic        fifo_r_en;
   logic        flush;
   logic [31:0] m_data;
   logic [3:0]  m_keep;
   logic        m_valid;
   logic        m_ready;
   logic        busy;

   logic [7:0]  mem [0:63];
   int          wr_cnt = 0;
   int          rd_cnt = 0;
   int          rd_err = 0;
   int          tests  = 0;
   int          fails  = 0;
   logic [35:0] cap [$];

   always #5 rclk = ~rclk;

   fifo_drain_packer dut (
      .rclk       (rclk),
      .rrst       (rrst),
      .fifo_empty (fifo_empty),
      .fifo_rdata (fifo_rdata),
      .fifo_r_en  (fifo_r_en),
      .flush      (flush),
      .m_data     (m_data),
      .m_keep     (m_keep),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .busy       (busy)
   );

   assign fifo_empty = (wr_cnt == rd_cnt);

   // FIFO read port with one-cycle latency, plus capture of accepted output words.
   always @(posedge rclk) begin
      if (fifo_r_en) begin
         if (fifo_empty) rd_err <= rd_err + 1;
         else begin
            fifo_rdata <= mem[6'(rd_cnt)];
            rd_cnt     <= rd_cnt + 1;
         end
      end
      if (!rrst && m_valid && m_ready) cap.push_back({m_keep, m_data});
   end

   task automatic push(input logic [7:0] b);
      mem[6'(wr_cnt)] = b;
      wr_cnt = wr_cnt + 1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge rclk);
   endtask

   task automatic wait_cap(input int n, input int budget, input string tag);
      int k = 0;
      while (cap.size() < n && k < budget) begin
         @(negedge rclk);
         k++;
      end
      chk({tag, "_count"}, 64'(cap.size()), 64'(n));
   endtask

   function automatic logic [35:0] cap_at(input int i);
      if (i < cap.size()) return cap[i];
      return '1;
   endfunction

   initial begin
      int base;
      rrst    = 1'b1;
      flush   = 1'b0;
      m_ready = 1'b1;
      cycles(3);
      chk("rst_m_valid", 64'(m_valid), 64'(0));
      chk("rst_m_data", 64'(m_data), 64'(0));
      chk("rst_m_keep", 64'(m_keep), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_r_en", 64'(fifo_r_en), 64'(0));

      // Empty FIFO: no reads, no words.
      rrst = 1'b0;
      cycles(20);
      chk("empty_rd_err", 64'(rd_err), 64'(0));
      chk("empty_words", 64'(cap.size()), 64'(0));
      chk("empty_busy", 64'(busy), 64'(0));

      // Eight bytes with downstream always ready.
      cap.delete();
      for (int i = 1; i <= 8; i++) push(8'(i));
      wait_cap(2, 60, "burst");
      chk("burst_w0", 64'(cap_at(0)), 64'({4'hF, 32'h04030201}));
      chk("burst_w1", 64'(cap_at(1)), 64'({4'hF, 32'h08070605}));
      cycles(3);
      chk("burst_busy_after", 64'(busy), 64'(0));

      // Backpressure with twelve bytes queued.
      cap.delete();
      m_ready = 1'b0;
      base    = rd_cnt;
      for (int i = 0; i < 12; i++) push(8'(8'h10 + i));
      cycles(40);
      chk("bp_valid", 64'(m_valid), 64'(1));
      chk("bp_data", 64'(m_data), 64'(32'h13121110));
      chk("bp_keep", 64'(m_keep), 64'(4'hF));
      chk("bp_reads", 64'(rd_cnt - base), 64'(8));
      chk("bp_r_en", 64'(fifo_r_en), 64'(0));
      chk("bp_busy", 64'(busy), 64'(1));
      cycles(5);
      chk("bp_hold_data", 64'(m_data), 64'(32'h13121110));
      chk("bp_hold_keep", 64'(m_keep), 64'(4'hF));
      m_ready = 1'b1;
      wait_cap(3, 60, "bp_release");
      chk("bp_w0", 64'(cap_at(0)), 64'({4'hF, 32'h13121110}));
      chk("bp_w1", 64'(cap_at(1)), 64'({4'hF, 32'h17161514}));
      chk("bp_w2", 64'(cap_at(2)), 64'({4'hF, 32'h1B1A1918}));

      // Flush with nothing accumulated is ignored.
      cap.delete();
      cycles(3);
      flush = 1'b1;
      cycles(1);
      flush = 1'b0;
      cycles(5);
      chk("idle_flush_words", 64'(cap.size()), 64'(0));
      chk("idle_flush_valid", 64'(m_valid), 64'(0));

      // Partial word flush.
      push(8'hAA);
      push(8'hBB);
      push(8'hCC);
      cycles(10);
      chk("part_no_early", 64'(cap.size()), 64'(0));
      flush = 1'b1;
      cycles(1);
      flush = 1'b0;
      wait_cap(1, 20, "flush");
      chk("flush_word", 64'(cap_at(0)), 64'({4'b0111, 32'h00CCBBAA}));

      // Reset mid-word with a held word pending and FIFO non-empty.
      cap.delete();
      m_ready = 1'b0;
      for (int i = 0; i < 4; i++) push(8'(8'h41 + i));
      push(8'h21);
      push(8'h22);
      cycles(20);
      chk("pre_rst_valid", 64'(m_valid), 64'(1));
      chk("pre_rst_busy", 64'(busy), 64'(1));
      rrst = 1'b1;
      for (int i = 0; i < 4; i++) push(8'(8'h31 + i));
      #1;
      chk("mid_rst_valid", 64'(m_valid), 64'(0));
      chk("mid_rst_data", 64'(m_data), 64'(0));
      chk("mid_rst_keep", 64'(m_keep), 64'(0));
      chk("mid_rst_busy", 64'(busy), 64'(0));
      chk("mid_rst_r_en", 64'(fifo_r_en), 64'(0));
      cycles(2);
      rrst    = 1'b0;
      m_ready = 1'b1;
      wait_cap(1, 30, "post_rst");
      chk("post_rst_word", 64'(cap_at(0)), 64'({4'hF, 32'h34333231}));
      cycles(5);
      chk("post_rst_only", 64'(cap.size()), 64'(1));

      // Single byte left idle.
      cap.delete();
      push(8'h5A);
`ifdef FIFO_DRAIN_PACKER_TIMEOUT_EN
      cycles(10);
      chk("timeout_not_early", 64'(cap.size()), 64'(0));
      wait_cap(1, 40, "timeout");
      chk("timeout_word", 64'(cap_at(0)), 64'({4'b0001, 32'h0000005A}));
`else
      cycles(40);
      chk("no_timeout_words", 64'(cap.size()), 64'(0));
      chk("no_timeout_busy", 64'(busy), 64'(1));
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
